// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM:
// opcodes, states, ALU operations and mux selects.
package cpu_ctrl_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_INC  = 4'b0101;
   localparam logic [3:0] OP_NEG  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_BRZ  = 4'b1001;
   localparam logic [3:0] OP_JM   = 4'b1010;
   localparam logic [3:0] OP_BRN  = 4'b1011;
   localparam logic [3:0] OP_LD   = 4'b1110;
   localparam logic [3:0] OP_SVPC = 4'b1111;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam int ALU_ADD   = 0;
   localparam int ALU_SUB   = 1;
   localparam int ALU_NEG   = 2;
   localparam int ALU_PASSA = 3;
   localparam int ALU_ADDPC = 4;

   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_RS  = 2'd1;
   localparam logic [1:0] PC_MEM = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged memory-request cycles and raises a sticky
// timeout; MAX = 0 disables expiry entirely.
module mem_wait_timer #(
   parameter int MAX = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic req,
   input  logic ack,
   input  logic restart,
   output logic expire,
   output logic timeout
);

   localparam int TW = (MAX > 1) ? $clog2(MAX) : 1;
   localparam logic [TW-1:0] LIMIT = (MAX > 0) ? TW'(MAX - 1) : '0;

   logic [TW-1:0] count;

   // Expiry lands on the MAX-th wait cycle; an ack that cycle wins.
   assign expire = (MAX != 0) && req && !ack && (count == LIMIT);

   always_ff @(posedge clock) begin
      if (reset) begin
         count   <= '0;
         timeout <= 1'b0;
      end else begin
         if (expire)
            timeout <= 1'b1;
         if (ack || restart || expire || !req)
            count <= '0;
         else
            count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM.
// Define ILLEGAL_TRAP_EN to trap undefined opcodes in HALT.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int ALU_OP_W     = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [3:0]          opcode,
   input  logic                z_flag,
   input  logic                n_flag,
   input  logic                mem_ack,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_ifetch,
   output logic                ir_we,
   output logic                pc_we,
   output logic [1:0]          pc_src,
   output logic                imm_gen_sel,
   output logic                alu_src_imm,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                reg_we,
   output logic [1:0]          wb_src,
   output logic                mem_timeout,
`ifdef ILLEGAL_TRAP_EN
   output logic                illegal_op,
`endif
   output logic                busy
);

   state_t state;
   state_t nxt;
   logic   req;
   logic   ack;
   logic   expire;
   logic   restart;

   assign req     = !reset && (state == S_FETCH || state == S_MEM);
   assign ack     = mem_ack && req;
   assign restart = (nxt != state);
   assign busy    = (state != S_FETCH);

`ifdef ILLEGAL_TRAP_EN
   assign illegal_op = (state == S_HALT);
`endif

   mem_wait_timer #(
      .MAX(MEM_WAIT_MAX)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .req    (req),
      .ack    (ack),
      .restart(restart),
      .expire (expire),
      .timeout(mem_timeout)
   );

   always_comb begin
      nxt         = state;
      mem_req     = req;
      mem_we      = 1'b0;
      mem_ifetch  = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PC_INC;
      imm_gen_sel = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = ALU_OP_W'(ALU_ADD);
      reg_we      = 1'b0;
      wb_src      = WB_ALU;
      unique case (state)
         S_FETCH: begin
            mem_ifetch = !reset;
            if (ack) begin
               ir_we = 1'b1;
               pc_we = 1'b1;
               nxt   = S_DECODE;
            end
         end
         S_DECODE: nxt = S_EXEC;
         S_EXEC: begin
            nxt = S_FETCH;
            unique case (opcode)
               OP_ADD: nxt = S_WB;
               OP_SUB: begin
                  alu_op = ALU_OP_W'(ALU_SUB);
                  nxt    = S_WB;
               end
               OP_NEG: begin
                  alu_op = ALU_OP_W'(ALU_NEG);
                  nxt    = S_WB;
               end
               OP_INC: begin
                  alu_src_imm = 1'b1;
                  nxt         = S_WB;
               end
               OP_SVPC: begin
                  imm_gen_sel = 1'b1;
                  alu_src_imm = 1'b1;
                  alu_op      = ALU_OP_W'(ALU_ADDPC);
                  nxt         = S_WB;
               end
               OP_LD, OP_ST, OP_JM: begin
                  alu_op = ALU_OP_W'(ALU_PASSA);
                  nxt    = S_MEM;
               end
               OP_J: begin
                  pc_we  = 1'b1;
                  pc_src = PC_RS;
               end
               OP_BRZ: begin
                  pc_we  = z_flag;
                  pc_src = PC_RS;
               end
               OP_BRN: begin
                  pc_we  = n_flag;
                  pc_src = PC_RS;
               end
               OP_NOP: nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
               default: nxt = S_HALT;
`else
               default: nxt = S_FETCH;
`endif
            endcase
         end
         S_MEM: begin
            mem_we = (opcode == OP_ST) && !reset;
            if (ack) begin
               nxt = (opcode == OP_LD) ? S_WB : S_FETCH;
               if (opcode == OP_JM) begin
                  pc_we  = 1'b1;
                  pc_src = PC_MEM;
               end
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            wb_src = (opcode == OP_LD) ? WB_MEM : WB_ALU;
            nxt    = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_HALT: nxt = S_HALT;
`endif
         default: nxt = S_FETCH;
      endcase
      if (expire)
         nxt = S_FETCH;
      // Reset silences every strobe, including a pending request.
      if (reset) begin
         nxt         = S_FETCH;
         ir_we       = 1'b0;
         pc_we       = 1'b0;
         pc_src      = PC_INC;
         imm_gen_sel = 1'b0;
         alu_src_imm = 1'b0;
         alu_op      = ALU_OP_W'(ALU_ADD);
         reg_we      = 1'b0;
         wb_src      = WB_ALU;
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= nxt;
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl with MEM_WAIT_MAX = 4.
// Directed per-cycle vectors are queued; a negedge monitor compares.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       mem_ifetch;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       imm_gen_sel;
      logic       alu_src_imm;
      logic [2:0] alu_op;
      logic       reg_we;
      logic [1:0] wb_src;
      logic       mem_timeout;
      logic       busy;
      logic       illegal;
   } out_t;

   logic       clock   = 1'b0;
   logic       reset   = 1'b1;
   logic [3:0] opcode  = 4'h0;
   logic       z_flag  = 1'b0;
   logic       n_flag  = 1'b0;
   logic       mem_ack = 1'b0;

   logic       mem_req, mem_we, mem_ifetch, ir_we, pc_we;
   logic [1:0] pc_src;
   logic       imm_gen_sel, alu_src_imm;
   logic [2:0] alu_op;
   logic       reg_we;
   logic [1:0] wb_src;
   logic       mem_timeout, busy;
   logic       illegal;

   out_t       act;
   out_t       exp_q[$];
   string      name_q[$];
   int         checks = 0;
   int         passed = 0;
   logic       tmo    = 1'b0;

   always #5 clock = ~clock;

   multicycle_ctrl #(
      .MEM_WAIT_MAX(4),
      .ALU_OP_W    (3)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .opcode     (opcode),
      .z_flag     (z_flag),
      .n_flag     (n_flag),
      .mem_ack    (mem_ack),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_ifetch (mem_ifetch),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .imm_gen_sel(imm_gen_sel),
      .alu_src_imm(alu_src_imm),
      .alu_op     (alu_op),
      .reg_we     (reg_we),
      .wb_src     (wb_src),
      .mem_timeout(mem_timeout),
`ifdef ILLEGAL_TRAP_EN
      .illegal_op (illegal),
`endif
      .busy       (busy)
   );

`ifndef ILLEGAL_TRAP_EN
   assign illegal = 1'b0;
`endif

   assign act = {mem_req, mem_we, mem_ifetch, ir_we, pc_we, pc_src,
                 imm_gen_sel, alu_src_imm, alu_op, reg_we, wb_src,
                 mem_timeout, busy, illegal};

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         out_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         checks++;
         if (act === e)
            passed++;
         else
            $display("FAIL %s: got %b required %b", nm, act, e);
      end
   end

   function automatic out_t zz(logic b);
      out_t e = '0;
      e.busy        = b;
      e.mem_timeout = tmo;
      return e;
   endfunction

   function automatic out_t fw();
      out_t e = zz(1'b0);
      e.mem_req    = 1'b1;
      e.mem_ifetch = 1'b1;
      return e;
   endfunction

   function automatic out_t fa();
      out_t e = fw();
      e.ir_we = 1'b1;
      e.pc_we = 1'b1;
      return e;
   endfunction

   function automatic out_t ex(logic [2:0] alu, logic imm, logic gen,
                               logic pcw, logic [1:0] ps);
      out_t e = zz(1'b1);
      e.alu_op      = alu;
      e.alu_src_imm = imm;
      e.imm_gen_sel = gen;
      e.pc_we       = pcw;
      e.pc_src      = ps;
      return e;
   endfunction

   function automatic out_t wb(logic [1:0] src);
      out_t e = zz(1'b1);
      e.reg_we = 1'b1;
      e.wb_src = src;
      return e;
   endfunction

   function automatic out_t mm(logic we, logic pcw, logic [1:0] ps);
      out_t e = zz(1'b1);
      e.mem_req = 1'b1;
      e.mem_we  = we;
      e.pc_we   = pcw;
      e.pc_src  = ps;
      return e;
   endfunction

   task automatic cyc(input string nm, input logic [3:0] op,
                      input logic z, input logic n, input logic ak,
                      input logic rst, input out_t e);
      @(posedge clock);
      #1;
      opcode  = op;
      z_flag  = z;
      n_flag  = n;
      mem_ack = ak;
      reset   = rst;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic fetch_decode(input string nm, input logic [3:0] op);
      cyc({nm, "_fetch"}, op, 0, 0, 1, 0, fa());
      cyc({nm, "_dec"}, op, 0, 0, 0, 0, zz(1'b1));
   endtask

   task automatic alu_instr(input string nm, input logic [3:0] op,
                            input logic [2:0] alu, input logic imm,
                            input logic gen);
      fetch_decode(nm, op);
      cyc({nm, "_exec"}, op, 0, 0, 0, 0, ex(alu, imm, gen, 0, 2'd0));
      cyc({nm, "_wb"}, op, 0, 0, 0, 0, wb(2'd0));
   endtask

   initial begin
      out_t h;
      @(posedge clock);
      #1;
      cyc("reset_idle", 4'h0, 0, 0, 0, 1, zz(1'b0));

      cyc("fetch_w1", 4'h4, 0, 0, 0, 0, fw());
      cyc("fetch_w2", 4'h4, 0, 0, 0, 0, fw());
      cyc("fetch_ack3", 4'h4, 0, 0, 1, 0, fa());
      cyc("add_dec_stray_ack", 4'h4, 0, 0, 1, 0, zz(1'b1));
      cyc("add_exec", 4'h4, 0, 0, 0, 0, ex(3'd0, 0, 0, 0, 2'd0));
      cyc("add_wb", 4'h4, 0, 0, 0, 0, wb(2'd0));

      alu_instr("inc", 4'h5, 3'd0, 1'b1, 1'b0);
      alu_instr("svpc", 4'hF, 3'd4, 1'b1, 1'b1);
      alu_instr("sub", 4'h7, 3'd1, 1'b0, 1'b0);
      alu_instr("neg", 4'h6, 3'd2, 1'b0, 1'b0);

      cyc("brz0_fetch", 4'h9, 0, 0, 1, 0, fa());
      cyc("brz0_dec_flagflip", 4'h9, 1, 1, 0, 0, zz(1'b1));
      cyc("brz0_exec", 4'h9, 0, 1, 0, 0, ex(3'd0, 0, 0, 0, 2'd1));
      fetch_decode("brz1", 4'h9);
      cyc("brz1_exec", 4'h9, 1, 0, 0, 0, ex(3'd0, 0, 0, 1, 2'd1));
      fetch_decode("brn1", 4'hB);
      cyc("brn1_exec", 4'hB, 0, 1, 0, 0, ex(3'd0, 0, 0, 1, 2'd1));
      fetch_decode("brn0", 4'hB);
      cyc("brn0_exec", 4'hB, 1, 0, 0, 0, ex(3'd0, 0, 0, 0, 2'd1));
      fetch_decode("j", 4'h8);
      cyc("j_exec", 4'h8, 0, 0, 0, 0, ex(3'd0, 0, 0, 1, 2'd1));

      fetch_decode("ld", 4'hE);
      cyc("ld_exec", 4'hE, 0, 0, 0, 0, ex(3'd3, 0, 0, 0, 2'd0));
      cyc("ld_mem_w1", 4'hE, 0, 0, 0, 0, mm(0, 0, 2'd0));
      cyc("ld_mem_w2", 4'hE, 0, 0, 0, 0, mm(0, 0, 2'd0));
      cyc("ld_mem_w3", 4'hE, 0, 0, 0, 0, mm(0, 0, 2'd0));
      cyc("ld_mem_ack_at_limit", 4'hE, 0, 0, 1, 0, mm(0, 0, 2'd0));
      cyc("ld_wb", 4'hE, 0, 0, 0, 0, wb(2'd1));
      cyc("ld_no_timeout", 4'hE, 0, 0, 0, 0, fw());

      fetch_decode("st", 4'h3);
      cyc("st_exec", 4'h3, 0, 0, 0, 0, ex(3'd3, 0, 0, 0, 2'd0));
      cyc("st_mem_w1", 4'h3, 0, 0, 0, 0, mm(1, 0, 2'd0));
      cyc("st_mem_ack", 4'h3, 0, 0, 1, 0, mm(1, 0, 2'd0));
      cyc("st_then_fetch", 4'h3, 0, 0, 0, 0, fw());

      fetch_decode("jm", 4'hA);
      cyc("jm_exec", 4'hA, 0, 0, 0, 0, ex(3'd3, 0, 0, 0, 2'd0));
      cyc("jm_mem_ack", 4'hA, 0, 0, 1, 0, mm(0, 1, 2'd2));

      fetch_decode("undef", 4'h1);
      cyc("undef_exec", 4'h1, 0, 0, 0, 0, zz(1'b1));
`ifdef ILLEGAL_TRAP_EN
      h = zz(1'b1);
      h.illegal = 1'b1;
      cyc("halt", 4'h1, 0, 0, 0, 0, h);
      cyc("halt_ack_ignored", 4'h1, 0, 0, 1, 0, h);
      cyc("halt_reset", 4'h1, 0, 0, 0, 1, h);
`else
      h = zz(1'b0);
`endif
      fetch_decode("nop", 4'h0);
      cyc("nop_exec", 4'h0, 0, 0, 0, 0, zz(1'b1));

      fetch_decode("rst_ld", 4'hE);
      cyc("rst_ld_exec", 4'hE, 0, 0, 0, 0, ex(3'd3, 0, 0, 0, 2'd0));
      cyc("rst_ld_mem", 4'hE, 0, 0, 0, 0, mm(0, 0, 2'd0));
      cyc("reset_mid_mem", 4'hE, 0, 0, 1, 1, zz(1'b1));
      cyc("post_reset_fetch", 4'hE, 0, 0, 0, 0, fw());

      fetch_decode("to", 4'hE);
      cyc("to_exec", 4'hE, 0, 0, 0, 0, ex(3'd3, 0, 0, 0, 2'd0));
      cyc("to_mem_w1", 4'hE, 0, 0, 0, 0, mm(0, 0, 2'd0));
      cyc("to_mem_w2", 4'hE, 0, 0, 0, 0, mm(0, 0, 2'd0));
      cyc("to_mem_w3", 4'hE, 0, 0, 0, 0, mm(0, 0, 2'd0));
      cyc("to_mem_w4", 4'hE, 0, 0, 0, 0, mm(0, 0, 2'd0));
      tmo = 1'b1;
      cyc("to_back_fetch", 4'h4, 0, 0, 0, 0, fw());
      cyc("fto_w2", 4'h4, 0, 0, 0, 0, fw());
      cyc("fto_w3", 4'h4, 0, 0, 0, 0, fw());
      cyc("fto_w4", 4'h4, 0, 0, 0, 0, fw());
      cyc("fto_refetch_ack", 4'h4, 0, 0, 1, 0, fa());
      cyc("sticky_dec", 4'h4, 0, 0, 0, 0, zz(1'b1));
      cyc("final_reset", 4'h4, 0, 0, 0, 1, zz(1'b1));
      tmo = 1'b0;
      cyc("timeout_cleared", 4'h4, 0, 0, 0, 0, fw());

      @(negedge clock);
      #1;
      if (exp_q.size() != 0)
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      $display("%0d/%0d checks passed", passed, checks + exp_q.size());
      $finish;
   end

endmodule
